// File: rtl/pcihellocore_out_leds.sv
`default_nettype none
// ============================================================================
//  Module      : pcihellocore_out_leds
//  Description : Avalon-MM slave output port for the game board LEDs and
//                seven-segment lines. Holds a 32-bit output register with
//                byte-enabled write, atomic bit set/clear, and a self-timed
//                pulse mask that is ORed onto the pins for PULSE_LEN cycles.
//  Ports       : clk, reset (async, active-high)
//                chipselect, address[2:0], write, writedata[31:0],
//                byteenable[3:0]      - Avalon-MM slave write/read side
//                readdata[31:0]       - registered read data, latency 1
//                out_port             - DATA | pulse_mask to the pins
//  Register map: 0 DATA, 1 PULSE_LEN, 4 OUTSET, 5 OUTCLEAR, 6 PULSE,
//                7 STATUS {busy, .., pulse_cnt}; 2/3 read 0
//  Revision    : 1.0 - initial release
// ============================================================================
module pcihellocore_out_leds #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    CNT_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  chipselect,
    input  logic [2:0]            address,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
    localparam logic [2:0] ADDR_PULSE     = 3'd6;
    localparam logic [2:0] ADDR_STATUS    = 3'd7;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] data;
    logic [CNT_WIDTH-1:0]  pulse_len;
    logic [DATA_WIDTH-1:0] pulse_mask;
    logic [CNT_WIDTH-1:0]  pulse_cnt;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wdata_ext;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] masked_wdata;
    logic [31:0]           data_word;
    logic [31:0]           pulse_mask_word;
    logic [31:0]           rd_next;
    logic                  busy;

    assign wr_en        = chipselect & write;
    assign masked_wdata = wdata_ext & lane_mask;
    assign busy         = (pulse_cnt != CNT_ZERO);

    // Bus-to-register width adaption. Bits beyond the 32-bit bus have no
    // byte lane and are never written by the host.
    for (genvar b = 0; b < DATA_WIDTH; b++) begin : g_wr_bits
        if (b < 32) begin : g_bus
            assign wdata_ext[b] = writedata[b];
            assign lane_mask[b] = byteenable[b/8];
        end else begin : g_pad
            assign wdata_ext[b] = 1'b0;
            assign lane_mask[b] = 1'b0;
        end
    end

    for (genvar b = 0; b < 32; b++) begin : g_rd_bits
        if (b < DATA_WIDTH) begin : g_reg
            assign data_word[b]       = data[b];
            assign pulse_mask_word[b] = pulse_mask[b];
        end else begin : g_zero
            assign data_word[b]       = 1'b0;
            assign pulse_mask_word[b] = 1'b0;
        end
    end

    // Output register: plain write, atomic set and atomic clear share it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= RESET_VALUE;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:     data <= (data & ~lane_mask) | masked_wdata;
                ADDR_OUTSET:   data <= data | masked_wdata;
                ADDR_OUTCLEAR: data <= data & ~masked_wdata;
                default:       data <= data;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_len <= '0;
        end else if (wr_en && (address == ADDR_PULSE_LEN)) begin
            pulse_len <= writedata[CNT_WIDTH-1:0];
        end
    end

    // Pulse engine. A qualifying PULSE write restarts mask and count outright;
    // otherwise the count runs down and the mask is dropped on the last cycle
    // so the mask can never outlive a zero count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_mask <= '0;
            pulse_cnt  <= '0;
        end else if (wr_en && (address == ADDR_PULSE) && (pulse_len != CNT_ZERO)) begin
            pulse_mask <= wdata_ext;
            pulse_cnt  <= pulse_len;
        end else if (pulse_cnt > CNT_ONE) begin
            pulse_cnt  <= pulse_cnt - CNT_ONE;
        end else if (pulse_cnt == CNT_ONE) begin
            pulse_cnt  <= '0;
            pulse_mask <= '0;
        end
    end

    // Read mux samples the registers before any same-edge write lands.
    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:      rd_next = data_word;
            ADDR_PULSE_LEN: rd_next[CNT_WIDTH-1:0] = pulse_len;
            ADDR_PULSE:     rd_next = pulse_mask_word;
            ADDR_STATUS: begin
                rd_next[31]            = busy;
                rd_next[CNT_WIDTH-1:0] = pulse_cnt;
            end
            default:        rd_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

    assign out_port = data | pulse_mask;

endmodule
`default_nettype wire

// File: tb/tb_pcihellocore_out_leds.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcihellocore_out_leds
//  Description : Directed self-checking bench for pcihellocore_out_leds.
//                Inputs change 1 ns after a rising edge; outputs are sampled
//                at the same point, i.e. showing the effect of that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pcihellocore_out_leds;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic [31:0] out_port;

    int tests_run = 0;
    int tests_failed = 0;

    pcihellocore_out_leds #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (16),
        .RESET_VALUE(32'h0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .address    (address),
        .write      (write),
        .writedata  (writedata),
        .byteenable (byteenable),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle bus write; afterwards the bus idles at the given address.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d,
                             input logic [3:0] be);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = d;
        byteenable = be;
        tick();
        write      = 1'b0;
        writedata  = 32'h0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        address    = 3'd0;
        write      = 1'b0;
        writedata  = 32'h0;
        byteenable = 4'h0;
        tick();
        tick();
        check("reset_out_port", out_port, 32'h0);
        check("reset_readdata", readdata, 32'h0);
        reset   = 1'b0;
        address = 3'd7;
        tick();
        check("status_after_reset", readdata, 32'h0);

        // Byte enables
        bus_write(3'd0, 32'hA5A5A5A5, 4'b1111);
        check("data_full_write", out_port, 32'hA5A5A5A5);
        bus_write(3'd0, 32'h12345678, 4'b0101);
        check("data_byte_enable", out_port, 32'hA534A578);
        address = 3'd0;
        tick();
        check("data_readback", readdata, 32'hA534A578);

        // Set / clear
        bus_write(3'd0, 32'h0000FF00, 4'b1111);
        bus_write(3'd4, 32'h00000003, 4'b1111);
        check("outset", out_port, 32'h0000FF03);
        bus_write(3'd5, 32'h00000F01, 4'b1111);
        check("outclear", out_port, 32'h0000F002);
        address = 3'd4;
        tick();
        check("outset_reads_zero", readdata, 32'h0);

        // Read during write returns the pre-write value, new value next edge
        bus_write(3'd0, 32'h00000011, 4'b1111);
        check("rdw_old_value", readdata, 32'h0000F002);
        tick();
        check("rdw_new_value", readdata, 32'h00000011);
        bus_write(3'd0, 32'h0, 4'b1111);

        // Pulse length 3 on bit31
        bus_write(3'd1, 32'd3, 4'b0000);
        address = 3'd1;
        tick();
        check("pulse_len_readback", readdata, 32'd3);
        bus_write(3'd6, 32'h80000000, 4'b1111);
        address = 3'd7;
        check("pulse_cycle1", out_port, 32'h80000000);
        tick();
        check("pulse_cycle2", out_port, 32'h80000000);
        check("status_3", readdata, 32'h80000003);
        tick();
        check("pulse_cycle3", out_port, 32'h80000000);
        check("status_2", readdata, 32'h80000002);
        tick();
        check("pulse_expired", out_port, 32'h0);
        check("status_1", readdata, 32'h80000001);
        tick();
        check("status_0", readdata, 32'h0);

        // Restart while busy
        bus_write(3'd1, 32'd5, 4'b1111);
        bus_write(3'd6, 32'h00000001, 4'b1111);
        check("restart_first", out_port, 32'h00000001);
        tick();
        tick();
        check("restart_first_held", out_port, 32'h00000001);
        bus_write(3'd6, 32'h00000002, 4'b1111);
        check("restart_replaces", out_port, 32'h00000002);
        tick();
        tick();
        tick();
        tick();
        check("restart_last_cycle", out_port, 32'h00000002);
        tick();
        check("restart_expired", out_port, 32'h0);

        // Zero pulse length: PULSE write has no effect
        bus_write(3'd1, 32'd0, 4'b1111);
        bus_write(3'd6, 32'h000000FF, 4'b1111);
        check("zero_len_out_port", out_port, 32'h0);
        address = 3'd7;
        tick();
        check("zero_len_status", readdata, 32'h0);

        // DATA bit shared with the pulse stays high after expiry
        bus_write(3'd4, 32'h00000100, 4'b1111);
        bus_write(3'd1, 32'd1, 4'b1111);
        bus_write(3'd6, 32'h00000300, 4'b1111);
        check("overlap_during", out_port, 32'h00000300);
        tick();
        check("overlap_after", out_port, 32'h00000100);

        // Reset mid-pulse
        bus_write(3'd0, 32'h00000005, 4'b1111);
        bus_write(3'd1, 32'd10, 4'b1111);
        bus_write(3'd6, 32'h000000F0, 4'b1111);
        address = 3'd7;
        tick();
        tick();
        check("pre_reset_pulse", out_port, 32'h000000F5);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_out_port", out_port, 32'h0);
        check("async_reset_readdata", readdata, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("no_resume_out_port", out_port, 32'h0);
        check("no_resume_status", readdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcihellocore_out_leds.md
# pcihellocore_out_leds

Avalon-MM slave output port that drives the game board's LEDs and seven-segment lines from the PCIe host. It is the write-side counterpart of the core's read-only input ports: the host writes a 32-bit output register, sets or clears individual bits atomically, and fires self-timed pulses (e.g. hit or score flashes) without software timing. It sits in the pcihellocore Avalon fabric behind the PCIe bridge, one clock domain.

## Interface
- DATA_WIDTH, 32, width of out_port and of all data registers
- CNT_WIDTH, 16, width of the pulse length and pulse counter
- RESET_VALUE, 32'h0, value of the DATA register after reset

- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- chipselect  in  1  slave select; writes are ignored when low
- address  in  3  word register index
- write  in  1  write strobe, single-cycle, zero wait states
- writedata  in  32  write data
- byteenable  in  4  byte lanes for DATA, OUTSET, OUTCLEAR
- readdata  out  32  registered read data, latency 1
- out_port  out  DATA_WIDTH  pin outputs

## Operation
- Write occurs on any edge with chipselect=1 and write=1.
- Register map:
  - 0 DATA (R/W): byte-enabled write; lanes with byteenable=0 keep their value.
  - 1 PULSE_LEN (R/W): writedata[CNT_WIDTH-1:0]; byteenable ignored.
  - 4 OUTSET (W): DATA |= writedata & lane mask. Reads 0.
  - 5 OUTCLEAR (W): DATA &= ~(writedata & lane mask). Reads 0.
  - 6 PULSE (R/W): loads pulse_mask <= writedata and pulse_cnt <= PULSE_LEN. If PULSE_LEN is 0, the write has no effect. A write while busy replaces both mask and count (restart, no OR).
  - 7 STATUS (RO): bit31 = busy (pulse_cnt != 0); bits[CNT_WIDTH-1:0] = pulse_cnt; other bits 0.
  - 2, 3: read 0, writes ignored.
- out_port = DATA | pulse_mask. It is combinational from registers only and has no path from the bus inputs.
- Pulse counter behaviour, per edge with no PULSE write:
  - If pulse_cnt > 1: decrement.
  - If pulse_cnt == 1: pulse_cnt <= 0 and pulse_mask <= 0.
  - If pulse_cnt == 0: hold.
- pulse_mask is always 0 when pulse_cnt is 0.
- A PULSE write takes priority over the decrement in the same cycle.
- DATA writes (0/4/5) during a pulse are independent. Bits set in both DATA and pulse_mask remain high after the pulse expires.
- Reset values, applied immediately on reset:
  - DATA = RESET_VALUE
  - PULSE_LEN = 0
  - pulse_mask = 0
  - pulse_cnt = 0
  - readdata = 0
  - out_port = RESET_VALUE
- Reset asserted mid-pulse aborts the pulse. There is no resume.

## Timing
- Write at edge k: the register is updated at edge k, and out_port shows the new value immediately after edge k.
- PULSE write at edge k with PULSE_LEN = N ≥ 1: mask bits are visible on out_port for exactly N cycles (after edge k through edge k+N), and cleared after edge k+N.
- readdata is updated on every edge from the register mux at the current address, with no read strobe. Register reads have no side effects.
- Read and write in the same cycle to the same address: readdata captures the pre-write value. The new value appears one edge later if address is held.
- No backpressure and no waitrequest. Every write completes in one cycle.

## Test plan
- Reset: assert reset asynchronously between edges -> out_port = RESET_VALUE and readdata = 0 at once; STATUS reads 0 after release.
- Byte enables: write DATA = 32'hA5A5A5A5 with byteenable 4'b1111, then 32'h12345678 with 4'b0101 -> out_port = 32'hA534A578; reading address 0 returns the same value.
- Set/clear: starting from DATA = 32'h0000FF00, OUTSET 32'h00000003 -> 32'h0000FF03; then OUTCLEAR 32'h00000F01 -> 32'h0000F002; address 4 reads 0.
- Pulse length: PULSE_LEN = 3, PULSE = 32'h80000000 at edge k -> bit31 high for exactly 3 cycles; STATUS reads 32'h80000003, then 2, then 1, then 32'h0.
- Pulse restart and zero length:
  - PULSE mask 1, LEN 5; after 2 cycles, PULSE mask 2 -> bit0 drops at once, bit1 high for 5 cycles.
  - With PULSE_LEN = 0, a PULSE write leaves out_port and STATUS unchanged.
- Reset mid-pulse: assert reset during a 10-cycle pulse -> mask clears immediately, and no pulse resumes after release.
